// File: rtl/psr_wim_unit_if.sv
// Bundle of control, flag and status signals between the integer core and the PSR/WIM unit.
// The master side is the core (or bench) driving requests; the slave side is the unit.
interface psr_wim_unit_if;
    logic        alu_valid;
    logic [5:0]  opcode;
    logic        N;
    logic        Z;
    logic        C;
    logic        V;
    logic        save_req;
    logic        restore_req;
    logic        trap_req;
    logic        rett_req;
    logic        wrpsr_en;
    logic        wrwim_en;
    logic [31:0] psr_wdata;
    logic [31:0] wim_wdata;
    logic [31:0] psr_out;
    logic [31:0] wim_out;
    logic [4:0]  cwp;
    logic        carry;
    logic        win_ovf;
    logic        win_unf;
    logic        op_err;

    modport master (
        output alu_valid, opcode, N, Z, C, V,
        output save_req, restore_req, trap_req, rett_req,
        output wrpsr_en, wrwim_en, psr_wdata, wim_wdata,
        input  psr_out, wim_out, cwp, carry, win_ovf, win_unf, op_err
    );

    modport slave (
        input  alu_valid, opcode, N, Z, C, V,
        input  save_req, restore_req, trap_req, rett_req,
        input  wrpsr_en, wrwim_en, psr_wdata, wim_wdata,
        output psr_out, wim_out, cwp, carry, win_ovf, win_unf, op_err
    );
endinterface

// File: rtl/psr_wim_unit.sv
// SPARC PSR and WIM holder: icc capture from the ALU, CWP tracking across
// SAVE/RESTORE/trap/RETT with WIM overflow/underflow detection.
module psr_wim_unit #(
    parameter int NWINDOWS = 8
) (
    input  logic           clk,
    input  logic           reset,
    psr_wim_unit_if.slave  bus
);

    localparam logic [4:0] LAST_WIN = 5'(NWINDOWS - 1);
    localparam logic [5:0] NWIN_6   = 6'(NWINDOWS);

    // icc is kept in PSR order {N, Z, V, C}, so bit 0 is the carry.
    logic [3:0]          icc_reg, icc_next;
    logic                s_reg, s_next;
    logic                ps_reg, ps_next;
    logic                et_reg, et_next;
    logic [4:0]          cwp_reg, cwp_next;
    logic [NWINDOWS-1:0] wim_reg, wim_next;
    logic                ovf_reg, ovf_next;
    logic                unf_reg, unf_next;
    logic                err_reg, err_next;

    logic [31:0] wim_full;
    logic [4:0]  cwp_dec;
    logic [4:0]  cwp_inc;
    logic        icc_load;
    logic        wrpsr_bad;

    // Zero-extend the stored mask to the architectural 32 bits.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_wim_full
            if (gi < NWINDOWS) begin : g_live
                assign wim_full[gi] = wim_reg[gi];
            end else begin : g_zero
                assign wim_full[gi] = 1'b0;
            end
        end
    endgenerate

    assign cwp_dec   = (cwp_reg == 5'd0)     ? LAST_WIN : cwp_reg - 5'd1;
    assign cwp_inc   = (cwp_reg == LAST_WIN) ? 5'd0     : cwp_reg + 5'd1;
    assign icc_load  = bus.alu_valid && !bus.opcode[5] && bus.opcode[4];
    assign wrpsr_bad = {1'b0, bus.psr_wdata[4:0]} >= NWIN_6;

    always_comb begin
        icc_next = icc_reg;
        s_next   = s_reg;
        ps_next  = ps_reg;
        et_next  = et_reg;
        cwp_next = cwp_reg;
        wim_next = wim_reg;
        ovf_next = 1'b0;
        unf_next = 1'b0;
        err_next = 1'b0;

        if (bus.trap_req) begin
            // Traps are taken even with ET=0; only the window check can block them.
            if (wim_full[cwp_dec]) begin
                ovf_next = 1'b1;
            end else begin
                et_next  = 1'b0;
                ps_next  = s_reg;
                s_next   = 1'b1;
                cwp_next = cwp_dec;
            end
        end else if (bus.rett_req) begin
            if (et_reg) begin
                err_next = 1'b1;
            end else if (wim_full[cwp_inc]) begin
                unf_next = 1'b1;
            end else begin
                cwp_next = cwp_inc;
                s_next   = ps_reg;
                et_next  = 1'b1;
            end
        end else if (bus.wrpsr_en) begin
            if (wrpsr_bad) begin
                err_next = 1'b1;
            end else begin
                icc_next = bus.psr_wdata[23:20];
                s_next   = bus.psr_wdata[7];
                ps_next  = bus.psr_wdata[6];
                et_next  = bus.psr_wdata[5];
                cwp_next = bus.psr_wdata[4:0];
            end
        end else begin
            if (bus.save_req && bus.restore_req) begin
                err_next = 1'b1;
            end else if (bus.save_req) begin
                if (wim_full[cwp_dec]) begin
                    ovf_next = 1'b1;
                end else begin
                    cwp_next = cwp_dec;
                end
            end else if (bus.restore_req) begin
                if (wim_full[cwp_inc]) begin
                    unf_next = 1'b1;
                end else begin
                    cwp_next = cwp_inc;
                end
            end
            // Flag capture rides along with window moves in the same cycle.
            if (icc_load) begin
                icc_next = {bus.N, bus.Z, bus.V, bus.C};
            end
        end

        // WIM writes are orthogonal; checks above always see the old mask.
        if (bus.wrwim_en) begin
            wim_next = bus.wim_wdata[NWINDOWS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            icc_reg <= 4'b0000;
            s_reg   <= 1'b1;
            ps_reg  <= 1'b0;
            et_reg  <= 1'b0;
            cwp_reg <= 5'd0;
            wim_reg <= '0;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            icc_reg <= icc_next;
            s_reg   <= s_next;
            ps_reg  <= ps_next;
            et_reg  <= et_next;
            cwp_reg <= cwp_next;
            wim_reg <= wim_next;
            ovf_reg <= ovf_next;
            unf_reg <= unf_next;
            err_reg <= err_next;
        end
    end

    assign bus.psr_out = {8'h00, icc_reg, 12'h000, s_reg, ps_reg, et_reg, cwp_reg};
    assign bus.wim_out = wim_full;
    assign bus.cwp     = cwp_reg;
    assign bus.carry   = icc_reg[0];
    assign bus.win_ovf = ovf_reg;
    assign bus.win_unf = unf_reg;
    assign bus.op_err  = err_reg;

    // Reserved PSR bits and low opcode bits carry no state here.
    logic unused_bits;
    assign unused_bits = ^{bus.opcode[3:0], bus.psr_wdata[31:24], bus.psr_wdata[19:8]};

    generate
        if (NWINDOWS < 32) begin : g_wim_unused
            logic unused_wim;
            assign unused_wim = ^bus.wim_wdata[31:NWINDOWS];
        end
    endgenerate

endmodule

// File: tb/tb_psr_wim_unit.sv
// Directed bench for psr_wim_unit: expected state is queued with each stimulus
// step and compared against the DUT one clock later.
module tb_psr_wim_unit;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    psr_wim_unit_if bus ();

    psr_wim_unit #(.NWINDOWS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] psr;
        logic [31:0] wim;
        logic [4:0]  cwp;
        logic        carry;
        logic [2:0]  pulses;   // {win_ovf, win_unf, op_err}
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic idle_inputs();
        reset           = 1'b0;
        bus.alu_valid   = 1'b0;
        bus.opcode      = 6'd0;
        bus.N           = 1'b0;
        bus.Z           = 1'b0;
        bus.C           = 1'b0;
        bus.V           = 1'b0;
        bus.save_req    = 1'b0;
        bus.restore_req = 1'b0;
        bus.trap_req    = 1'b0;
        bus.rett_req    = 1'b0;
        bus.wrpsr_en    = 1'b0;
        bus.wrwim_en    = 1'b0;
        bus.psr_wdata   = 32'd0;
        bus.wim_wdata   = 32'd0;
    endtask

    task automatic check_one(input string tag, input string field,
                             input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s.%s: got %h want %h", tag, field, obs, exp);
    endtask

    // Queue the expectation, clock once, then compare the oldest entry.
    task automatic step(input string tag, input logic [31:0] psr, input logic [31:0] wim,
                        input logic [4:0] c, input logic carry, input logic [2:0] pulses);
        exp_t e;
        e.tag = tag; e.psr = psr; e.wim = wim; e.cwp = c; e.carry = carry; e.pulses = pulses;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            $error("FAIL %s.queue: got empty want entry", tag);
        end else begin
            e = sb.pop_front();
            check_one(e.tag, "psr",    bus.psr_out, e.psr);
            check_one(e.tag, "wim",    bus.wim_out, e.wim);
            check_one(e.tag, "cwp",    {27'd0, bus.cwp}, {27'd0, e.cwp});
            check_one(e.tag, "carry",  {31'd0, bus.carry}, {31'd0, e.carry});
            check_one(e.tag, "pulses", {29'd0, bus.win_ovf, bus.win_unf, bus.op_err},
                      {29'd0, e.pulses});
            $display("step %-12s psr=%h wim=%h cwp=%0d carry=%b ovf/unf/err=%b%b%b",
                     e.tag, bus.psr_out, bus.wim_out, bus.cwp, bus.carry,
                     bus.win_ovf, bus.win_unf, bus.op_err);
        end
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();

        reset = 1'b1;
        step("reset",      32'h00000080, 32'h0, 5'd0, 1'b0, 3'b000);
        step("idle",       32'h00000080, 32'h0, 5'd0, 1'b0, 3'b000);

        // icc capture: S-opcode loads, plain and shift opcodes do not.
        bus.alu_valid = 1'b1; bus.opcode = 6'b010000;
        bus.N = 1'b0; bus.Z = 1'b1; bus.C = 1'b1; bus.V = 1'b0;
        step("icc_load",   32'h00500080, 32'h0, 5'd0, 1'b1, 3'b000);
        bus.alu_valid = 1'b1; bus.opcode = 6'b000000;
        bus.N = 1'b1; bus.Z = 1'b0; bus.C = 1'b0; bus.V = 1'b1;
        step("icc_nos",    32'h00500080, 32'h0, 5'd0, 1'b1, 3'b000);
        bus.alu_valid = 1'b1; bus.opcode = 6'b100101;
        bus.N = 1'b1; bus.Z = 1'b1; bus.C = 1'b0; bus.V = 1'b1;
        step("icc_shift",  32'h00500080, 32'h0, 5'd0, 1'b1, 3'b000);

        // Window wrap with an empty mask.
        bus.save_req = 1'b1;
        step("save_wrap",  32'h00500087, 32'h0, 5'd7, 1'b1, 3'b000);
        bus.restore_req = 1'b1;
        step("rest_wrap",  32'h00500080, 32'h0, 5'd0, 1'b1, 3'b000);
        bus.save_req = 1'b1; bus.restore_req = 1'b1;
        step("save_rest",  32'h00500080, 32'h0, 5'd0, 1'b1, 3'b001);

        // WIM masking and overflow/underflow.
        bus.wrwim_en = 1'b1; bus.wim_wdata = 32'hFFFF0080;
        step("wrwim_80",   32'h00500080, 32'h80, 5'd0, 1'b1, 3'b000);
        bus.save_req = 1'b1;
        step("save_ovf",   32'h00500080, 32'h80, 5'd0, 1'b1, 3'b100);
        bus.save_req = 1'b1; bus.wrwim_en = 1'b1; bus.wim_wdata = 32'h00000001;
        step("save_wim",   32'h00500080, 32'h01, 5'd0, 1'b1, 3'b100);
        bus.save_req = 1'b1;
        step("save_ok",    32'h00500087, 32'h01, 5'd7, 1'b1, 3'b000);
        bus.restore_req = 1'b1;
        step("rest_unf",   32'h00500087, 32'h01, 5'd7, 1'b1, 3'b010);
        step("idle2",      32'h00500087, 32'h01, 5'd7, 1'b1, 3'b000);

        // PSR write, trap, RETT.
        bus.wrpsr_en = 1'b1; bus.psr_wdata = 32'h00000023;
        bus.wrwim_en = 1'b1; bus.wim_wdata = 32'h0;
        step("wrpsr_23",   32'h00000023, 32'h0, 5'd3, 1'b0, 3'b000);
        bus.trap_req = 1'b1;
        step("trap",       32'h00000082, 32'h0, 5'd2, 1'b0, 3'b000);
        bus.rett_req = 1'b1;
        step("rett",       32'h00000023, 32'h0, 5'd3, 1'b0, 3'b000);
        bus.rett_req = 1'b1;
        step("rett_et1",   32'h00000023, 32'h0, 5'd3, 1'b0, 3'b001);
        step("idle3",      32'h00000023, 32'h0, 5'd3, 1'b0, 3'b000);

        // Priority: trap beats save and icc capture.
        bus.trap_req = 1'b1; bus.save_req = 1'b1;
        bus.alu_valid = 1'b1; bus.opcode = 6'b010000;
        bus.N = 1'b1; bus.Z = 1'b1; bus.C = 1'b1; bus.V = 1'b1;
        step("trap_prio",  32'h00000082, 32'h0, 5'd2, 1'b0, 3'b000);
        bus.wrpsr_en = 1'b1; bus.psr_wdata = 32'h00F000C9;
        step("wrpsr_bad",  32'h00000082, 32'h0, 5'd2, 1'b0, 3'b001);

        // Trap wraps CWP 0 -> 7, then blocked trap and blocked RETT.
        bus.wrpsr_en = 1'b1; bus.psr_wdata = 32'h00000020;
        step("wrpsr_20",   32'h00000020, 32'h0, 5'd0, 1'b0, 3'b000);
        bus.trap_req = 1'b1;
        step("trap_wrap",  32'h00000087, 32'h0, 5'd7, 1'b0, 3'b000);
        bus.wrwim_en = 1'b1; bus.wim_wdata = 32'h00000040;
        step("wrwim_40",   32'h00000087, 32'h40, 5'd7, 1'b0, 3'b000);
        bus.trap_req = 1'b1;
        step("trap_ovf",   32'h00000087, 32'h40, 5'd7, 1'b0, 3'b100);
        bus.wrwim_en = 1'b1; bus.wim_wdata = 32'h00000001;
        step("wrwim_01",   32'h00000087, 32'h01, 5'd7, 1'b0, 3'b000);
        bus.rett_req = 1'b1;
        step("rett_unf",   32'h00000087, 32'h01, 5'd7, 1'b0, 3'b010);

        // Reset overrides a simultaneous trap and clears pulses.
        bus.trap_req = 1'b1; bus.rett_req = 1'b1;
        reset = 1'b1;
        step("reset_trap", 32'h00000080, 32'h0, 5'd0, 1'b0, 3'b000);
        step("idle4",      32'h00000080, 32'h0, 5'd0, 1'b0, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
